ntt_result_drain: RTL
=====================

# ntt_result_drain

Host-side reader for the NTT result FIFO. On a start pulse it pops a fixed number of 32-bit result words from the dual-clock result FIFO, which runs in normal, non-show-ahead mode. Each word is packed as {data_out2, data_out1}. The block splits each word into two 16-bit coefficients and presents them, with a running coefficient address, on a valid/ready stream toward the host bridge. It is the consumer end of the path that the NTT core writes on every cal_done.

## Interface
- N_WORDS, 128: result words per transform; 2·N_WORDS coefficients are emitted.
- TIMEOUT, 1024: consecutive empty-FIFO cycles tolerated in FETCH; used only with the timeout feature.
- clk  input  1  block clock; also the FIFO read clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a drain; ignored while busy=1.
- fifo_rd_req  output  1  FIFO read request.
- fifo_rd_empty  input  1  FIFO empty flag.
- fifo_rd_dat  input  32  FIFO read data, valid one clk after fifo_rd_req.
- out_valid  output  1  coefficient valid.
- out_ready  input  1  host accepts coefficient.
- out_data  output  16  coefficient.
- out_addr  output  8  coefficient index, 0..2·N_WORDS-1, modulo 256.
- out_last  output  1  high with the final coefficient.
- busy  output  1  drain in progress.
- done  output  1  one-cycle pulse on completion.
- err  output  1  sticky timeout flag.

## Operation
- States: IDLE, FETCH, WAIT, EMIT_LO, EMIT_HI, DONE, ERR.
- IDLE: on start, clear word_cnt, out_addr and err, then go to FETCH. busy=1 in every state except IDLE.
- FETCH: if fifo_rd_empty=0, assert fifo_rd_req for exactly one cycle and go to WAIT. Otherwise stay in FETCH; fifo_rd_req is never asserted while empty.
- WAIT: latch fifo_rd_dat into a 32-bit hold register, increment word_cnt, go to EMIT_LO.
- EMIT_LO: out_valid=1, out_data=hold[15:0]. On out_valid&out_ready: out_addr+1, go to EMIT_HI.
- EMIT_HI: out_valid=1, out_data=hold[31:16]. On acceptance: out_addr+1. If word_cnt==N_WORDS go to DONE, else go to FETCH.
- out_last=1 only in EMIT_HI when word_cnt==N_WORDS.
- DONE: done=1 for one cycle, then go to IDLE.
- out_data and out_addr hold steady while out_valid=1 and out_ready=0. The stream must never drop or duplicate a coefficient.
- out_addr wraps 255→0. word_cnt is wide enough to hold N_WORDS without wrapping.
- Words still in the FIFO after N_WORDS are left untouched.

## Timing
- Reset values: fifo_rd_req=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, err=0, state=IDLE, hold=0, word_cnt=0.
- start in cycle t: busy=1 at t+1. The first fifo_rd_req comes no earlier than t+1 (FETCH with FIFO non-empty).
- fifo_rd_req at cycle f: data latched at f+1, out_valid=1 from f+2.
- Best case, out_ready held high: 4 cycles per word (FETCH, WAIT, LO, HI), i.e. 2 coefficients per 4 clk.
- done pulses the cycle after the final EMIT_HI acceptance. busy falls one cycle later.
- start while busy: no effect. start in the same cycle as DONE: ignored; the new drain begins from the next start seen in IDLE.
- rst_n low mid-drain: all outputs return to reset values immediately. A word already requested from the FIFO is lost and is not re-read.

## Configuration
- DRAIN_TIMEOUT_EN defined:
  - a counter runs in FETCH while fifo_rd_empty=1 and clears on any read;
  - when it reaches TIMEOUT, go to ERR;
  - ERR lasts one cycle with busy=1, then the block returns to IDLE with err=1 and done=0;
  - err stays high until the next accepted start or reset.
- DRAIN_TIMEOUT_EN undefined: FETCH waits indefinitely, err is tied to 0, and the ERR state and counter are not built.

## Test plan
- Basic drain: preload the FIFO with words 0x0002_0001..0x0100_00FF, N_WORDS=128, out_ready=1, pulse start. Required: coefficients 0x0001, 0x0002, … at addresses 0..255; out_last only at addr 255; done exactly once; 512 cycles from first rd_req to done ±2.
- Backpressure: out_ready toggles pseudo-randomly. Required: identical data/address sequence, with out_data stable whenever stalled.
- FIFO starvation: load 3 words, start, add the remaining words 50 cycles later. Required: no fifo_rd_req while empty; output correct and complete.
- start while busy: second start mid-drain. Required: no restart, out_addr continues, a single done pulse.
- Reset mid-drain: rst_n low after 10 coefficients. Required: all outputs 0 asynchronously and state IDLE; a new start drains the remaining words from addr 0.
- DRAIN_TIMEOUT_EN, TIMEOUT=16: start with an empty FIFO. Required: err=1 about 17 cycles after entering FETCH, busy then 0, no done; the next start clears err.

Source files
------------

// File: rtl/ntt_result_drain.sv
// Host-side drain of the NTT result FIFO: pops N_WORDS words and streams them as 16-bit coefficients.
// Optional FETCH starvation timeout is built only when DRAIN_TIMEOUT_EN is defined.
module ntt_result_drain #(
    parameter int unsigned N_WORDS = 128,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        fifo_rd_req,
    input  logic        fifo_rd_empty,
    input  logic [31:0] fifo_rd_dat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [7:0]  out_addr,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int unsigned CntW = $clog2(N_WORDS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N_WORDS);

    if (N_WORDS == 0 || TIMEOUT == 0) begin : g_bad_params
        $error("ntt_result_drain: N_WORDS and TIMEOUT must be non-zero");
    end

`ifdef DRAIN_TIMEOUT_EN
    typedef enum logic [2:0] {
        StIdle, StFetch, StWait, StEmitLo, StEmitHi, StDone, StErr
    } state_e;

    localparam int unsigned ToW = $clog2(TIMEOUT + 1);
    logic [ToW-1:0] to_cnt;
`else
    typedef enum logic [2:0] {
        StIdle, StFetch, StWait, StEmitLo, StEmitHi, StDone
    } state_e;

    assign err = 1'b0;
`endif

    state_e          state;
    logic [31:0]     hold;
    logic [CntW-1:0] word_cnt;

    // The FIFO is non-show-ahead, so the request must track the live empty flag.
    assign fifo_rd_req = (state == StFetch) && !fifo_rd_empty;
    assign out_data    = (state == StEmitHi) ? hold[31:16] : hold[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            hold      <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DRAIN_TIMEOUT_EN
            err       <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        word_cnt <= '0;
                        out_addr <= '0;
                        busy     <= 1'b1;
                        state    <= StFetch;
`ifdef DRAIN_TIMEOUT_EN
                        err      <= 1'b0;
                        to_cnt   <= '0;
`endif
                    end
                end
                StFetch: begin
                    if (!fifo_rd_empty) begin
                        state <= StWait;
`ifdef DRAIN_TIMEOUT_EN
                        to_cnt <= '0;
                    end else if (to_cnt == ToW'(TIMEOUT - 1)) begin
                        state <= StErr;
                    end else begin
                        to_cnt <= to_cnt + ToW'(1);
`endif
                    end
                end
                StWait: begin
                    hold      <= fifo_rd_dat;
                    word_cnt  <= word_cnt + CntW'(1);
                    out_valid <= 1'b1;
                    state     <= StEmitLo;
                end
                StEmitLo: begin
                    if (out_ready) begin
                        out_addr <= out_addr + 8'd1;
                        out_last <= (word_cnt == LastCnt);
                        state    <= StEmitHi;
                    end
                end
                StEmitHi: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_addr  <= out_addr + 8'd1;
                        if (word_cnt == LastCnt) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            state <= StFetch;
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
`ifdef DRAIN_TIMEOUT_EN
                StErr: begin
                    busy  <= 1'b0;
                    err   <= 1'b1;
                    state <= StIdle;
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end
endmodule
